// File: rtl/cpu_controller_pkg.sv
// Shared opcode/phase encodings for the 8-bit RISC CPU controller.
// Optional build macro used elsewhere: CPU_CONTROLLER_PERF_EN.
package cpu_controller_pkg;

  localparam int PHASE_WIDTH = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [PHASE_WIDTH-1:0] PHASE_INST_ADDR  = 3'd0;
  localparam logic [PHASE_WIDTH-1:0] PHASE_INST_FETCH = 3'd1;
  localparam logic [PHASE_WIDTH-1:0] PHASE_INST_LOAD  = 3'd2;
  localparam logic [PHASE_WIDTH-1:0] PHASE_IDLE       = 3'd3;
  localparam logic [PHASE_WIDTH-1:0] PHASE_OP_ADDR    = 3'd4;
  localparam logic [PHASE_WIDTH-1:0] PHASE_OP_FETCH   = 3'd5;
  localparam logic [PHASE_WIDTH-1:0] PHASE_ALU_OP     = 3'd6;
  localparam logic [PHASE_WIDTH-1:0] PHASE_STORE      = 3'd7;

  // Opcodes whose result passes through the ALU into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath strobe bundle; master = controller, slave = datapath.
// Strobes are level signals qualified by the phase; there is no valid/ready handshake.
interface cpu_controller_if;
  import cpu_controller_pkg::*;

  logic [2:0]             opcode;
  logic                   zero;
  logic                   sel;
  logic                   rd;
  logic                   ld_ir;
  logic                   inc_pc;
  logic                   ld_pc;
  logic                   ld_ac;
  logic                   wr;
  logic                   data_e;
  logic                   halt;
  logic [PHASE_WIDTH-1:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

endinterface

// File: rtl/cpu_phase_counter.sv
// Free-running 8-phase instruction cycle counter; holds its value while frozen.
module cpu_phase_counter
  import cpu_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    output logic [PHASE_WIDTH-1:0] phase
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PHASE_INST_ADDR;
        end else if (!freeze) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: decodes phase/opcode/zero into datapath strobes.
// Build macro CPU_CONTROLLER_PERF_EN adds a saturating retired-instruction counter.
module cpu_controller
  import cpu_controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    cpu_controller_if.master bus
`ifdef CPU_CONTROLLER_PERF_EN
    ,
    output logic [15:0] instr_count
`endif
);

    logic [PHASE_WIDTH-1:0] phase;
    logic                   halted;
    logic                   aluop;

    cpu_phase_counter u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (halted),
        .phase  (phase)
    );

    // HLT still bumps the PC in OP_ADDR; the counter then parks at OP_FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (phase == PHASE_OP_ADDR && bus.opcode == OP_HLT) begin
            halted <= 1'b1;
        end
    end

`ifdef CPU_CONTROLLER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 16'd0;
        end else if (phase == PHASE_STORE && !halted && instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

    assign aluop     = is_aluop(bus.opcode);
    assign bus.phase = phase;
    assign bus.halt  = halted;

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        if (!halted) begin
            case (phase)
                PHASE_INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                PHASE_INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                PHASE_INST_LOAD, PHASE_IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                PHASE_OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                end
                PHASE_OP_FETCH: begin
                    bus.rd = aluop;
                end
                PHASE_ALU_OP: begin
                    bus.rd     = aluop;
                    bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.data_e = (bus.opcode == OP_STO);
                end
                default: begin
                    bus.rd     = aluop;
                    bus.ld_ac  = aluop;
                    bus.inc_pc = (bus.opcode == OP_JMP);
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.wr     = (bus.opcode == OP_STO);
                    bus.data_e = (bus.opcode == OP_STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed table-driven bench for cpu_controller (optional CPU_CONTROLLER_PERF_EN checks).
module tb_cpu_controller;
    import cpu_controller_pkg::*;

    typedef struct {
        logic [2:0]      opcode;
        logic            zero;
        logic [7:0][7:0] exp;   // exp[p] = {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e} in phase p
    } vec_t;

    logic clk;
    logic rst_n;
    cpu_controller_if bus ();
`ifdef CPU_CONTROLLER_PERF_EN
    logic [15:0] instr_count;
`endif

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef CPU_CONTROLLER_PERF_EN
        ,
        .instr_count (instr_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int exp_instr = 0;
    vec_t vecs[9];

    function automatic logic [7:0] strobes();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called at a negedge with the phase at 0; returns at the negedge of the next phase 0.
    task automatic run_instr(input vec_t v, input int idx);
        bus.opcode = v.opcode;
        for (int p = 0; p < 8; p++) begin
            bus.zero = (p == 6) ? v.zero : ~v.zero;
            #1;
            check($sformatf("v%0d_p%0d_phase", idx, p), {29'd0, bus.phase}, p);
            check($sformatf("v%0d_p%0d_strobes", idx, p), {24'd0, strobes()}, {24'd0, v.exp[p]});
            check($sformatf("v%0d_p%0d_halt", idx, p), {31'd0, bus.halt}, 32'd0);
            @(negedge clk);
        end
        exp_instr++;
    endtask

    initial begin
        vec_t add_row;
        rst_n      = 1'b0;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;

        // Rows list phase 7 first, phase 0 last.
        vecs[0] = '{OP_ADD, 1'b0, {8'h44, 8'h40, 8'h40, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[1] = '{OP_AND, 1'b1, {8'h44, 8'h40, 8'h40, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[2] = '{OP_XOR, 1'b0, {8'h44, 8'h40, 8'h40, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[3] = '{OP_LDA, 1'b1, {8'h44, 8'h40, 8'h40, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[4] = '{OP_STO, 1'b0, {8'h03, 8'h01, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[5] = '{OP_SKZ, 1'b1, {8'h00, 8'h10, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[6] = '{OP_SKZ, 1'b0, {8'h00, 8'h00, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[7] = '{OP_JMP, 1'b0, {8'h18, 8'h08, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        vecs[8] = '{OP_JMP, 1'b1, {8'h18, 8'h08, 8'h00, 8'h10, 8'hE0, 8'hE0, 8'hC0, 8'h80}};
        add_row = vecs[0];

        // reset state held across several edges
        repeat (3) @(negedge clk);
        check("rst_phase", {29'd0, bus.phase}, 32'd0);
        check("rst_strobes", {24'd0, strobes()}, 32'h80);
        check("rst_halt", {31'd0, bus.halt}, 32'd0);
`ifdef CPU_CONTROLLER_PERF_EN
        check("rst_count", {16'd0, instr_count}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_instr(vecs[i], i);

`ifdef CPU_CONTROLLER_PERF_EN
        check("count_after_table", {16'd0, instr_count}, exp_instr);
`endif

        // asynchronous reset in the middle of an ADD
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_phase_pre", {29'd0, bus.phase}, 32'd6);
        check("mid_strobes_pre", {24'd0, strobes()}, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("mid_phase_rst", {29'd0, bus.phase}, 32'd0);
        check("mid_strobes_rst", {24'd0, strobes()}, 32'h80);
        exp_instr = 0;
`ifdef CPU_CONTROLLER_PERF_EN
        check("mid_count_rst", {16'd0, instr_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(add_row, 9);
        run_instr(vecs[4], 10);

        // HLT: fetch normally, inc_pc in OP_ADDR, then park at OP_FETCH
        bus.opcode = OP_HLT;
        for (int p = 0; p < 5; p++) begin
            bus.zero = p[0];
            #1;
            check($sformatf("hlt_p%0d_phase", p), {29'd0, bus.phase}, p);
            check($sformatf("hlt_p%0d_strobes", p), {24'd0, strobes()}, {24'd0, add_row.exp[p]});
            check($sformatf("hlt_p%0d_halt", p), {31'd0, bus.halt}, 32'd0);
            @(negedge clk);
        end
        for (int c = 0; c < 24; c++) begin
            bus.zero = c[0];
            #1;
            check($sformatf("halted_c%0d_phase", c), {29'd0, bus.phase}, 32'd5);
            check($sformatf("halted_c%0d_strobes", c), {24'd0, strobes()}, 32'd0);
            check($sformatf("halted_c%0d_halt", c), {31'd0, bus.halt}, 32'd1);
            @(negedge clk);
        end
`ifdef CPU_CONTROLLER_PERF_EN
        check("count_halted", {16'd0, instr_count}, exp_instr);
`endif

        // only reset leaves the halted state
        #2 rst_n = 1'b0;
        #1;
        check("unhalt_phase", {29'd0, bus.phase}, 32'd0);
        check("unhalt_halt", {31'd0, bus.halt}, 32'd0);
        check("unhalt_strobes", {24'd0, strobes()}, 32'h80);
        exp_instr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(vecs[7], 11);
`ifdef CPU_CONTROLLER_PERF_EN
        check("count_final", {16'd0, instr_count}, exp_instr);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit RISC CPU.
- Drives the bus-select, memory, IR, PC and accumulator strobes from a free-running 8-phase cycle, the current 3-bit opcode and the ALU zero flag.
- It is the consumer side of the ALU interface: the ALU produces the zero flag and the data path carries the ALU result; this block decides when those are loaded, stored or used for branching.

Parameters:
- None. Opcode encodings and phase encodings come from the shared package.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  3  IR opcode field (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7)
- zero  input  1  ALU is_zero flag, combinational from the accumulator
- sel  output  1  address mux: 1=PC, 0=IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment PC
- ld_pc  output  1  load PC from IR operand
- ld_ac  output  1  load accumulator from ALU out
- wr  output  1  memory write strobe
- data_e  output  1  drive ALU out onto data bus
- halt  output  1  CPU halted, sticky
- phase  output  3  current phase, debug

Behaviour:
- Reset is decided: one clock; reset is asynchronous and active-low.
- On reset: phase=INST_ADDR(0) and halted=0. Outputs decode to sel=1 and all other strobes 0.
- Phase register: 0..7, +1 per clk, wraps 7->0. Phase names: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- Outputs are Moore-style combinational decode of (phase, registered halted, opcode, zero). No added latency.
- Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Decode per phase (signals not listed are 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=(opcode==JMP); ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- HLT handling:
  - In OP_ADDR with opcode==HLT, inc_pc is still 1, and halted is set at the end of that cycle.
  - While halted: phase freezes at OP_FETCH(5); halt=1; all strobes 0 (sel=0).
  - Only rst_n clears halted.
- Opcode is assumed stable from IDLE through STORE. The controller does not latch it.
- zero is sampled only in ALU_OP. Its value in any other phase has no effect.
- Reset asserted mid-instruction: strobes return to reset values immediately (asynchronously). The next instruction starts at INST_ADDR after rst_n deasserts.
- Each instruction takes exactly 8 cycles, except HLT, which stops.

Optional Feature:
- Macro: CPU_CONTROLLER_PERF_EN.
- Defined:
  - Adds output port instr_count [15:0].
  - Counter increments on each STORE->INST_ADDR transition while not halted; saturates at 0xFFFF.
  - Reset value 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package/defines file (existing opcode defines) extended with:
  - PHASE_* 3-bit localparams.
  - The PHASE_WIDTH constant.
  - An ALUOP membership macro/function.
- One natural sub-module: cpu_phase_counter, which holds the 3-bit wrap counter with a freeze input driven by halted. Output decode stays in cpu_controller.

Test Plan:
- Reset/fetch: hold rst_n=0, then release. Phases 0,1,2,3 -> sel=1; rd=0,1,1,1; ld_ir=0,0,1,1. phase==0 at first post-reset edge.
- ADD, opcode=2, zero=0:
  - OP_ADDR: inc_pc=1.
  - OP_FETCH and ALU_OP: rd=1.
  - STORE: ld_ac=1, rd=1, wr=0.
  - Then the next instruction begins at phase 0.
- STO, opcode=6:
  - ALU_OP: data_e=1, wr=0, rd=0.
  - STORE: data_e=1, wr=1, ld_ac=0.
- SKZ, opcode=1: with zero=1, ALU_OP gives inc_pc=1. Repeat with zero=0: inc_pc=0. Toggling zero in phases other than ALU_OP has no effect.
- JMP, opcode=7: ALU_OP gives ld_pc=1, inc_pc=0. STORE gives ld_pc=1, inc_pc=1.
- HLT, opcode=0:
  - OP_ADDR: inc_pc=1.
  - Afterwards halt=1 and phase stays 5 for 20+ cycles with all strobes 0.
  - Pulse rst_n low mid-cycle: halt=0 and phase=0 asynchronously.
  - With PERF_EN: instr_count equals the number of completed non-HLT instructions.
